// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions for the front end.
//   XLEN          : architectural register / address width
//   NOP_INST      : canonical NOP (addi x0, x0, 0)
//   fetch_entry_t : one fetched instruction together with its PC
//   align_word    : forces an address onto a 4-byte boundary
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched {inst, pc} entries for the decode stage.
// The head entry is read straight from the storage registers, so the head is
// visible the cycle after it is pushed.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   push, push_data: write one entry (caller guarantees the FIFO is not full)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the FIFO; overrides a same-cycle push and pop
//   head           : current head entry ({NOP, RESET_PC} out of reset)
//   count          : number of valid entries
// -----------------------------------------------------------------------------
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    fetch_entry_t  mem_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;

    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] wr_en;

    // A flush discards everything, including whatever arrives this cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count_reg != '0) && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Entries are reset so that the head shows a NOP at RESET_PC while empty
    // out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '{inst: NOP_INST, pc: RESET_PC};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= push_data;
                end
            end
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: issues word-aligned requests to instruction memory,
// collects in-order responses into a fetch queue and presents the queue head
// to decode. Redirects flush the queue and silently drop responses that were
// already in flight.
//   i_clk, i_rst_n                  : clock, asynchronous active-low reset
//   i_redirect, i_redirect_target   : redirect pulse and new fetch PC
//   o_imem_req, o_imem_addr         : fetch request and word address
//   i_imem_gnt                      : request accepted this cycle
//   i_imem_rvalid, i_imem_rdata     : in-order response
//   o_valid, i_ready                : decode handshake on the queue head
//   o_inst, o_pc, o_pc_plus_4       : head instruction, its PC and PC + 4
// -----------------------------------------------------------------------------
module if_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR      = 32'h00000000,
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = FQ_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus_4
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] MAX_OUT   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_reg, discard_next;

    logic [CW-1:0]   fq_count;
    logic [CW:0]     credit_sum;
    logic            grant;
    logic            resp;
    logic            resp_keep;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // Every queue slot is either occupied or reserved by an in-flight request,
    // so a response can never find the queue full. Discarded responses still
    // hold their reservation until they come back.
    assign credit_sum = {1'b0, fq_count} + {1'b0, outstanding_reg};
    assign o_imem_req = i_rst_n && !i_redirect
                        && (outstanding_reg < MAX_OUT)
                        && (credit_sum < DEPTH_EXT);
    assign o_imem_addr = fetch_pc_reg;

    assign grant = o_imem_req && i_imem_gnt;
    // A response with nothing outstanding is a protocol violation; ignore it.
    assign resp      = i_imem_rvalid && (outstanding_reg != '0);
    assign resp_keep = resp && (discard_reg == '0);
    assign pop       = o_valid && i_ready;

    assign push_entry = '{inst: i_imem_rdata, pc: resp_pc_reg};

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;

        case ({grant, resp})
            2'b10:   outstanding_next = outstanding_reg + CNT_ONE;
            2'b01:   outstanding_next = outstanding_reg - CNT_ONE;
            default: outstanding_next = outstanding_reg;
        endcase

        if (grant) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        if (resp_keep) begin
            resp_pc_next = resp_pc_reg + 32'd4;
        end
        if (resp && (discard_reg != '0)) begin
            discard_next = discard_reg - CNT_ONE;
        end

        // No request is issued in a redirect cycle, so outstanding_next
        // already reflects this cycle's response: everything still in flight
        // belongs to the old path and must be dropped.
        if (i_redirect) begin
            fetch_pc_next = align_word(i_redirect_target);
            resp_pc_next  = align_word(i_redirect_target);
            discard_next  = outstanding_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_reg    <= RESET_ADDR;
            resp_pc_reg     <= RESET_ADDR;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    fetch_fifo #(
        .DEPTH    (FQ_DEPTH),
        .RESET_PC (RESET_ADDR)
    ) u_fetch_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (resp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (i_redirect),
        .head      (head),
        .count     (fq_count)
    );

    assign o_valid     = (fq_count != '0);
    assign o_inst      = head.inst;
    assign o_pc        = head.pc;
    assign o_pc_plus_4 = head.pc + 32'd4;

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h00000000;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam int          NV         = 17;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_target = '0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus_4;

    always #5 i_clk = ~i_clk;

    if_fetch_unit #(
        .RESET_ADDR      (RESET_ADDR),
        .FQ_DEPTH        (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_redirect        (i_redirect),
        .i_redirect_target (i_redirect_target),
        .o_imem_req        (o_imem_req),
        .o_imem_addr       (o_imem_addr),
        .i_imem_gnt        (i_imem_gnt),
        .i_imem_rvalid     (i_imem_rvalid),
        .i_imem_rdata      (i_imem_rdata),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_inst            (o_inst),
        .o_pc              (o_pc),
        .o_pc_plus_4       (o_pc_plus_4)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] cyc = '0;
    logic [31:0] last_due = '0;
    bit          gnt_rand = 1'b0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic [31:0] expect_pc = RESET_ADDR;
    int          pops = 0;
    bit          granted = 1'b0;
    logic [31:0] granted_addr = '0;
    int          gcnt = 0;
    logic [31:0] gaddr [8];

    typedef struct packed {
        logic        ready;
        logic        redirect;
        logic [31:0] target;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579BDF;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] tgt,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic evalid, input logic [31:0] epc);
        vec_t v;
        v.ready     = rdy;
        v.redirect  = rd;
        v.target    = tgt;
        v.exp_req   = ereq;
        v.exp_addr  = eaddr;
        v.exp_valid = evalid;
        v.exp_pc    = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        last_due  = '0;
        expect_pc = RESET_ADDR;
    endtask

    // Drive the memory side for this cycle, let outputs settle, then record
    // grants/responses and score any instruction handed to decode.
    task automatic prep();
        int unsigned lat;
        logic [31:0] d;
        if (gnt_rand) i_imem_gnt = ($urandom_range(0, 1) == 1);
        else          i_imem_gnt = 1'b1;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(pend_q[0].addr);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
        end
        #1;
        if (i_imem_rvalid) void'(pend_q.pop_front());
        granted = o_imem_req && i_imem_gnt;
        if (granted) begin
            lat = $urandom_range(lat_min, lat_max);
            d   = cyc + 32'(lat);
            if (d <= last_due) d = last_due + 32'd1;
            last_due = d;
            pend_q.push_back('{addr: o_imem_addr, due: d});
            granted_addr = o_imem_addr;
            if (gcnt < 8) gaddr[gcnt] = o_imem_addr;
            gcnt++;
        end
        if (i_redirect) begin
            expect_pc = {i_redirect_target[31:2], 2'b00};
        end else if (o_valid && i_ready) begin
            chk("pop_pc", o_pc, expect_pc);
            chk("pop_inst", o_inst, mem_word(expect_pc));
            chk("pop_pc_plus_4", o_pc_plus_4, expect_pc + 32'd4);
            expect_pc = expect_pc + 32'd4;
            pops++;
        end
    endtask

    task automatic adv();
        @(posedge i_clk);
        @(negedge i_clk);
        cyc = cyc + 32'd1;
    endtask

    task automatic do_reset();
        i_rst_n       = 1'b0;
        i_redirect    = 1'b0;
        i_ready       = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        gcnt = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(o_imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_pc"},    o_pc, RESET_ADDR);
        chk({tag, "_inst"},  o_inst, NOP);
        chk({tag, "_pc4"},   o_pc_plus_4, RESET_ADDR + 32'd4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int p0;

        // Cycle-by-cycle vectors, latency 1, grant always high.
        vecs[0]  = mk(1, 0, 32'h0,        1, 32'h00000000, 0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h0,        1, 32'h00000004, 0, 32'h0);
        vecs[2]  = mk(1, 0, 32'h0,        1, 32'h00000008, 1, 32'h00000000);
        vecs[3]  = mk(1, 0, 32'h0,        1, 32'h0000000C, 1, 32'h00000004);
        vecs[4]  = mk(1, 0, 32'h0,        1, 32'h00000010, 1, 32'h00000008);
        vecs[5]  = mk(1, 0, 32'h0,        1, 32'h00000014, 1, 32'h0000000C);
        vecs[6]  = mk(1, 1, 32'h103,      0, 32'h0,        1, 32'h00000010);
        vecs[7]  = mk(1, 0, 32'h0,        1, 32'h00000100, 0, 32'h0);
        vecs[8]  = mk(1, 0, 32'h0,        1, 32'h00000104, 0, 32'h0);
        vecs[9]  = mk(1, 0, 32'h0,        1, 32'h00000108, 1, 32'h00000100);
        vecs[10] = mk(1, 0, 32'h0,        1, 32'h0000010C, 1, 32'h00000104);
        vecs[11] = mk(1, 1, 32'hFFFFFFF9, 0, 32'h0,        1, 32'h00000108);
        vecs[12] = mk(1, 0, 32'h0,        1, 32'hFFFFFFF8, 0, 32'h0);
        vecs[13] = mk(1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0);
        vecs[14] = mk(1, 0, 32'h0,        1, 32'h00000000, 1, 32'hFFFFFFF8);
        vecs[15] = mk(1, 0, 32'h0,        1, 32'h00000004, 1, 32'hFFFFFFFC);
        vecs[16] = mk(1, 0, 32'h0,        1, 32'h00000008, 1, 32'h00000000);

        // Reset state
        i_rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        #1;
        chk_reset_outputs("reset");
        $display("reset: req=%0b valid=%0b pc=%h inst=%h", o_imem_req, o_valid, o_pc, o_inst);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Table: streaming, redirect to unaligned target, address wrap
        gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
        for (int v = 0; v < NV; v++) begin
            i_ready           = vecs[v].ready;
            i_redirect        = vecs[v].redirect;
            i_redirect_target = vecs[v].target;
            prep();
            chk($sformatf("vec%0d_req", v), 32'(o_imem_req), 32'(vecs[v].exp_req));
            if (vecs[v].exp_req) chk($sformatf("vec%0d_addr", v), o_imem_addr, vecs[v].exp_addr);
            chk($sformatf("vec%0d_valid", v), 32'(o_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d_pc", v), o_pc, vecs[v].exp_pc);
                chk($sformatf("vec%0d_pc4", v), o_pc_plus_4, vecs[v].exp_pc + 32'd4);
            end
            $display("vec %0d: redirect=%0b req=%0b addr=%h valid=%0b pc=%h inst=%h",
                     v, i_redirect, o_imem_req, o_imem_addr, o_valid, o_pc, o_inst);
            adv();
        end
        i_redirect = 1'b0;

        // Stalled decode: queue fills, requests stop at the credit limit
        do_reset();
        gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
        i_ready = 1'b0;
        repeat (8) begin prep(); adv(); end
        prep();
        chk("stall_grants", 32'(gcnt), 32'd4);
        chk("stall_gaddr0", gaddr[0], 32'h0);
        chk("stall_gaddr1", gaddr[1], 32'h4);
        chk("stall_gaddr2", gaddr[2], 32'h8);
        chk("stall_gaddr3", gaddr[3], 32'hC);
        chk("stall_req", 32'(o_imem_req), 32'd0);
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_pc", o_pc, 32'h0);
        $display("stall: grants=%0d req=%0b head_pc=%h", gcnt, o_imem_req, o_pc);
        adv();
        i_ready = 1'b1;
        prep();
        chk("release_req_same_cycle", 32'(o_imem_req), 32'd0);
        adv();
        prep();
        chk("release_req", 32'(o_imem_req), 32'd1);
        chk("release_addr", o_imem_addr, 32'h10);
        $display("release: req=%0b addr=%h", o_imem_req, o_imem_addr);
        adv();
        repeat (6) begin prep(); adv(); end

        // Redirect with three requests in flight at latency 3
        do_reset();
        gnt_rand = 1'b0; lat_min = 3; lat_max = 3;
        i_ready = 1'b1;
        repeat (3) begin prep(); adv(); end
        i_redirect = 1'b1;
        i_redirect_target = 32'h200;
        prep();
        chk("inflight_grants", 32'(gcnt), 32'd3);
        chk("inflight_valid", 32'(o_valid), 32'd0);
        adv();
        i_redirect = 1'b0;
        gcnt = 0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            prep();
            if (granted && gcnt == 1) chk("redirect_first_addr", granted_addr, 32'h200);
            if (o_valid) begin
                found = 1'b1;
                chk("redirect_first_pc", o_pc, 32'h200);
                chk("redirect_first_inst", o_inst, mem_word(32'h200));
                $display("redirect: first valid pc=%h inst=%h after %0d cycles", o_pc, o_inst, c);
            end
            adv();
        end
        chk("redirect_valid_seen", 32'(found), 32'd1);

        // Asynchronous reset with requests outstanding
        do_reset();
        gnt_rand = 1'b0; lat_min = 3; lat_max = 3;
        i_ready = 1'b0;
        repeat (5) begin prep(); adv(); end
        prep();
        chk("midreset_pre_valid", 32'(o_valid), 32'd1);
        chk("midreset_pre_pc", o_pc, 32'h0);
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        $display("midreset: req=%0b valid=%0b pc=%h inst=%h", o_imem_req, o_valid, o_pc, o_inst);
        model_reset();
        i_imem_rvalid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        prep();
        chk("postreset_req", 32'(o_imem_req), 32'd1);
        chk("postreset_addr", o_imem_addr, RESET_ADDR);
        adv();
        i_ready = 1'b1;
        repeat (8) begin prep(); adv(); end

        // Random traffic: grant/latency/ready/redirect all randomised
        do_reset();
        gnt_rand = 1'b1; lat_min = 1; lat_max = 5;
        p0 = pops;
        for (int c = 0; c < 3000; c++) begin
            i_ready           = ($urandom_range(0, 9) < 7);
            i_redirect        = ($urandom_range(0, 49) == 0);
            i_redirect_target = $urandom;
            prep();
            adv();
        end
        i_redirect = 1'b0;
        chk("random_progress", 32'((pops - p0) > 300), 32'd1);
        $display("random: delivered=%0d instructions", pops - p0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
